// File: rtl/imem_fetch_responder.sv
// -----------------------------------------------------------------------------
// imem_fetch_responder
//
// Instruction-memory responder for the fetch side of the 32I core. Accepts a
// single fetch request (byte address from the IF stage), waits WAIT_CYCLES
// programmable wait states, reads the instruction word from an internal RAM
// and returns it on a valid/ready response channel. Only one request is ever
// outstanding. A flush (branch/jump redirect) drops the in-flight request and
// no response is produced for it. A side load port writes program words at
// any time, including while reset is asserted.
//
// Handshake semantics (both channels):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer holds valid and its payload stable until that edge. On the
//   request side an asserted flush vetoes the transfer (flush wins over
//   req_valid while IDLE), so the accept condition is
//   req_valid & req_ready & ~flush. A response that meets rsp_ready on the
//   same edge as flush is dropped; the consumer must ignore it.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   req_valid  fetch request present
//   req_addr   byte address of the instruction
//   req_ready  responder can accept a request (IDLE and out of reset)
//   flush      drop the in-flight request, no response is produced
//   rsp_valid  response present
//   rsp_inst   fetched instruction (NOP_INST on error)
//   rsp_err    misaligned or out-of-range address
//   rsp_addr   echo of the accepted req_addr
//   rsp_ready  consumer accepts the response
//   ld_en      program-load write strobe
//   ld_addr    word index for the load
//   ld_data    word to write
//   dbg_state  current FSM state (observation only)
// -----------------------------------------------------------------------------
module imem_fetch_responder #(
  parameter int          DEPTH_LOG2  = 10,
  parameter int          WAIT_CYCLES = 1,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_inst,
  output logic                  rsp_err,
  output logic [31:0]           rsp_addr,
  input  logic                  rsp_ready,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data,
  output logic [1:0]            dbg_state
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Counter value loaded on accept; the WAIT state lasts WAIT_CYCLES cycles
  // because it leaves when the counter has already reached zero.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]            wait_cnt;
  logic [31:0]           addr_q;
  logic                  accept;
  logic                  enter_resp;
  logic [31:0]           cap_addr;
  logic                  cap_err;
  logic [DEPTH_LOG2-1:0] cap_idx;

  logic [31:0] mem [0:DEPTH-1];

  // ---------------------------------------------------------------------------
  // Program RAM: written by the load port on any edge, never cleared.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (wait_cnt == 4'd0) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        // A flush coinciding with rsp_ready still returns to IDLE; the
        // response is treated as dropped by the consumer.
        if (flush || rsp_ready) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // req_ready is held low while reset is asserted and rises as soon as it
    // is released.
    req_ready = (state == S_IDLE) && reset;
    rsp_valid = (state == S_RESP);
    dbg_state = state;
  end

  // ---------------------------------------------------------------------------
  // Request accept and response capture
  // ---------------------------------------------------------------------------
  assign accept = req_valid && req_ready && !flush;

  // Response registers load on the edge that enters RESP, from either the
  // WAIT state (latched address) or directly from IDLE when there are no
  // wait states (address taken straight from the request).
  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);
  assign cap_addr   = (state == S_IDLE) ? req_addr : addr_q;
  assign cap_err    = (cap_addr[1:0] != 2'b00) || (cap_addr[31:DEPTH_LOG2+2] != '0);
  assign cap_idx    = cap_addr[DEPTH_LOG2+1:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= 4'd0;
      addr_q   <= 32'd0;
      rsp_inst <= 32'd0;
      rsp_err  <= 1'b0;
      rsp_addr <= 32'd0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr;
        wait_cnt <= WAIT_LOAD;
      end else if ((state == S_WAIT) && (wait_cnt != 4'd0)) begin
        wait_cnt <= wait_cnt - 4'd1;
      end

      if (enter_resp) begin
        rsp_addr <= cap_addr;
        rsp_err  <= cap_err;
        // The RAM read sees the pre-edge contents, so a load to the same
        // word on this edge is not visible in this response.
        if (cap_err) begin
          rsp_inst <= NOP_INST;
        end else begin
          rsp_inst <= mem[cap_idx];
        end
      end
    end
  end

endmodule
